fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Program-counter and fetch sequencer for the 9-bit core. It drives the address of the combinational instruction ROM and registers the returned word into a one-entry fetch buffer. The buffer is presented to decode over a valid/ready handshake. The block also handles taken-branch redirects, halt detection, out-of-range faults and the start/done run control.

Parameters:
ROM_SIZE, 512, number of instruction words; address width AW = $clog2(ROM_SIZE)+1 (10 at default)
INSTR_WIDTH, 9, instruction width in bits
HALT_WORD, 9'b111000000, encoding that ends a program
START_ADDR, 0, PC loaded on start

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from START_ADDR
instr_addr  out  AW  ROM address, combinational
instr_in  in  INSTR_WIDTH  ROM read data, valid in the same cycle as instr_addr
instr  out  INSTR_WIDTH  fetch-buffer instruction
instr_pc  out  AW  address the buffered instruction came from
instr_valid  out  1  fetch buffer holds an instruction
instr_ready  in  1  decode accepts the buffer this cycle
br_taken  in  1  qualifies the accept: the accepted instruction is a taken branch
br_target  in  AW  branch destination, sampled only with br_taken
done  out  1  run finished (halt or fault); sticky until next start
fault  out  1  run ended by fetch at or beyond ROM_SIZE; sticky until next start

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, pc=START_ADDR
  - instr=0, instr_pc=0, instr_valid=0
  - done=0, fault=0
- Definitions:
  - accept = instr_valid & instr_ready
  - fetch_en = state==RUN & (!instr_valid | instr_ready)
- instr_addr = (accept & br_taken) ? br_target : pc. It shows pc even when no fetch is enabled.
- State IDLE:
  - instr_valid=0.
  - start moves to RUN, loads pc=START_ADDR, and clears done and fault.
- State RUN, on fetch_en:
  - If instr_addr >= ROM_SIZE: fault=1, done=1, instr_valid=0, go to IDLE. No load.
  - Otherwise: instr<=instr_in, instr_pc<=instr_addr, instr_valid<=1, pc<=instr_addr+1.
  - If instr_in==HALT_WORD, go to DRAIN. The halt word is still presented.
- State RUN, on accept without a new fetch: not possible. Any accept in RUN implies fetch_en.
- Stall: instr_valid=1 and instr_ready=0 holds instr, instr_pc and pc unchanged. instr_addr keeps showing pc.
- State DRAIN:
  - No fetches. instr_addr=pc, and its data is ignored.
  - br_taken is ignored.
  - On accept of the halt word: instr_valid<=0, done<=1, go to IDLE.
- Latency and throughput:
  - First instruction is valid 2 cycles after the start pulse: start edge, then fetch edge.
  - Throughput is 1 instruction per cycle with instr_ready held high.
  - A taken branch costs zero bubbles, because the target is fetched in the accept cycle.
- start outside IDLE is ignored. A start in the same cycle as the DRAIN accept is ignored; the block lands in IDLE.
- pc arithmetic is AW-bit unsigned. pc=ROM_SIZE-1 fetches normally; the next fetch faults.
- br_taken without accept has no effect.
- Reset mid-run aborts immediately to reset values. No partial instruction is presented.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output instr_count (16 bits). It counts accepts in RUN and DRAIN, halt included, and saturates at 16'hFFFF.
  - Cleared by reset and by an accepted start.
  - Adds output stall_count (16 bits). It counts cycles with instr_valid=1 and instr_ready=0, saturates, and clears the same way.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
1. ROM holds words 0..4 = 9'h046, halt at 5; instr_ready=1; pulse start.
   - instr_valid rises 2 cycles later with instr_pc 0,1,2,3,4,5 on consecutive cycles.
   - done=1 the cycle after the halt is accepted; fault=0.
2. Backpressure: hold instr_ready=0 for 3 cycles while instr_pc=2.
   - instr, instr_pc=2 and pc=3 are stable.
   - On release, instr_pc sequence is 2,3 with no loss or duplicate.
3. Branch: accept instr_pc=7 with br_taken=1, br_target=40.
   - instr_addr=40 that cycle; next instr_pc=40, then 41. No bubble.
4. Fault: no halt; run to pc=511.
   - instr_pc=511 is presented; on its accept, done=1, fault=1, instr_valid=0.
   - A new start clears both flags.
5. Reset: deassert rst_n mid-run at instr_pc=20.
   - All outputs drop to reset values asynchronously; start then restarts from instr_pc=0.
6. With FETCH_PERF_CNT_EN: scenario 1 plus 3 stall cycles gives instr_count=6 and stall_count=3.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter and fetch sequencer for the 9-bit core.
// Drives the combinational instruction ROM address, registers the returned
// word into a one-entry fetch buffer presented to decode over valid/ready,
// and handles taken-branch redirects, halt draining, out-of-range faults and
// start/done run control.
// Optional feature: define FETCH_PERF_CNT_EN to add the instr_count and
// stall_count performance counters.
module fetch_ctrl #(
    parameter int                     ROM_SIZE    = 512,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 9'b111000000,
    parameter int                     START_ADDR  = 0,
    localparam int                    AW          = $clog2(ROM_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [AW-1:0]          instr_addr,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [AW-1:0]          instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   br_taken,
    input  logic [AW-1:0]          br_target,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]            instr_count,
    output logic [15:0]            stall_count,
`endif
    output logic                   done,
    output logic                   fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // The extra address bit lets pc step past the last word so the next
    // fetch can be recognised as out of range.
    localparam logic [AW-1:0] ROM_LIMIT = AW'(ROM_SIZE);
    localparam logic [AW-1:0] START_PC  = AW'(START_ADDR);

    state_t                 r_state;
    logic [AW-1:0]          r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [AW-1:0]          r_instr_pc;
    logic                   r_valid;
    logic                   r_done;
    logic                   r_fault;

    state_t                 w_state_nxt;
    logic [AW-1:0]          w_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic [AW-1:0]          w_instr_pc_nxt;
    logic                   w_valid_nxt;
    logic                   w_done_nxt;
    logic                   w_fault_nxt;

    logic                   w_accept;
    logic                   w_fetch_en;
    logic                   w_redirect;
    logic [AW-1:0]          w_addr;
    logic                   w_out_of_range;
    logic                   w_start_ok;

    // Handshake qualifiers; a redirect only exists in RUN, so DRAIN ignores
    // br_taken and keeps showing pc.
    assign w_accept       = r_valid & instr_ready;
    assign w_fetch_en     = (r_state == S_RUN) & (~r_valid | instr_ready);
    assign w_redirect     = (r_state == S_RUN) & w_accept & br_taken;
    assign w_addr         = w_redirect ? br_target : r_pc;
    assign w_out_of_range = (w_addr >= ROM_LIMIT);
    assign w_start_ok     = (r_state == S_IDLE) & start;

    assign instr_addr  = w_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign done        = r_done;
    assign fault       = r_fault;

    // Next-state and next-datapath decode for the run-control FSM.
    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no
        // path through the case can leave a value unassigned and infer a latch.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_done_nxt     = r_done;
        w_fault_nxt    = r_fault;

        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_PC;
                    w_done_nxt  = 1'b0;
                    w_fault_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (w_fetch_en) begin
                    if (w_out_of_range) begin
                        // Fetch beyond the ROM ends the run; the buffer is not loaded.
                        w_fault_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_instr_nxt    = instr_in;
                        w_instr_pc_nxt = w_addr;
                        w_valid_nxt    = 1'b1;
                        w_pc_nxt       = w_addr + AW'(1);
                        // The halt word is still presented; DRAIN waits for its accept.
                        if (instr_in == HALT_WORD) begin
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept) begin
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and fetch-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= START_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_instr_count;
    logic [15:0] r_stall_count;
    logic        w_count_accept;
    logic        w_count_stall;

    assign w_count_accept = w_accept & ((r_state == S_RUN) | (r_state == S_DRAIN));
    assign w_count_stall  = r_valid & ~instr_ready;

    // Saturating accept and stall counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else if (w_start_ok) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_count_accept && (r_instr_count != 16'hFFFF)) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
            if (w_count_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;
`else
    // Without the counters an accepted start has no further side effects.
    logic w_unused_start_ok;
    assign w_unused_start_ok = w_start_ok;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: run to halt with drain backpressure,
// fetch-buffer stall, zero-bubble branch, fetch fault at the ROM boundary,
// and asynchronous reset mid-run. Counter checks apply when
// FETCH_PERF_CNT_EN is defined.
module tb_fetch_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          instr_ready = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic [AW-1:0] instr_addr;
    logic [AW-1:0] instr_pc;
    logic [8:0]    instr_in;
    logic [8:0]    instr;
    logic          instr_valid;
    logic          done;
    logic          fault;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   instr_count;
    logic [15:0]   stall_count;
`endif

    logic [8:0]    rom [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_addr  (instr_addr),
        .instr_in    (instr_in),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
`ifdef FETCH_PERF_CNT_EN
        .instr_count (instr_count),
        .stall_count (stall_count),
`endif
        .done        (done),
        .fault       (fault)
    );

    // Combinational ROM model.
    assign instr_in = rom[instr_addr];

    always #5 clk = ~clk;

    // Background word for address a: never equal to the halt encoding.
    function automatic logic [8:0] pat(input int a);
        return {1'b0, a[7:0]};
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < 1024; i++) rom[i] = pat(i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic step(input logic s, input logic rdy, input logic bt, input int tgt);
        @(negedge clk);
        start       = s;
        instr_ready = rdy;
        br_taken    = bt;
        br_target   = AW'(tgt);
        #1;
    endtask

    task automatic expect_word(input int ipc, input int ins, input int addr);
        chk($sformatf("valid@%0d", ipc), 32'(instr_valid), 1);
        chk($sformatf("instr_pc@%0d", ipc), 32'(instr_pc), ipc);
        chk($sformatf("instr@%0d", ipc), 32'(instr), ins);
        chk($sformatf("addr@%0d", ipc), 32'(instr_addr), addr);
        chk($sformatf("done@%0d", ipc), 32'(done), 0);
        chk($sformatf("fault@%0d", ipc), 32'(fault), 0);
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 0);
        chk({tag, "_instr"}, 32'(instr), 0);
        chk({tag, "_pc"}, 32'(instr_pc), 0);
        chk({tag, "_addr"}, 32'(instr_addr), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_pattern();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        expect_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Run to halt: words 0..4, halt at 5, three stall cycles on the halt.
        for (int i = 0; i < 5; i++) rom[i] = 9'h046;
        rom[5] = 9'h1C0;
        step(1'b1, 1'b1, 1'b0, 0);
        chk("s1_start_valid", 32'(instr_valid), 0);
        chk("s1_start_addr", 32'(instr_addr), 0);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s1_lat_valid", 32'(instr_valid), 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            expect_word(k, 'h046, k + 1);
        end
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b0, 1'b0, 0);
            expect_word(5, 'h1C0, 6);
        end
        // Halt accept with start and a branch request: both must be ignored.
        step(1'b1, 1'b1, 1'b1, 40);
        expect_word(5, 'h1C0, 6);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s1_end_valid", 32'(instr_valid), 0);
        chk("s1_end_done", 32'(done), 1);
        chk("s1_end_fault", 32'(fault), 0);
        chk("s1_end_addr", 32'(instr_addr), 6);
`ifdef FETCH_PERF_CNT_EN
        chk("s1_instr_count", 32'(instr_count), 6);
        chk("s1_stall_count", 32'(stall_count), 3);
`endif
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s1_idle_valid", 32'(instr_valid), 0);
        chk("s1_idle_done", 32'(done), 1);

        // Backpressure, branch and fault at the ROM boundary.
        fill_pattern();
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s2_lat_valid", 32'(instr_valid), 0);
        chk("s2_lat_done", 32'(done), 0);
`ifdef FETCH_PERF_CNT_EN
        chk("s2_instr_count_clr", 32'(instr_count), 0);
        chk("s2_stall_count_clr", 32'(stall_count), 0);
`endif
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            expect_word(k, 32'(pat(k)), k + 1);
        end
        step(1'b0, 1'b0, 1'b0, 0);
        expect_word(2, 32'(pat(2)), 3);
        // Branch request without accept has no effect.
        step(1'b0, 1'b0, 1'b1, 100);
        expect_word(2, 32'(pat(2)), 3);
        step(1'b0, 1'b0, 1'b0, 0);
        expect_word(2, 32'(pat(2)), 3);
        step(1'b0, 1'b1, 1'b0, 0);
        expect_word(2, 32'(pat(2)), 3);
        for (int k = 3; k < 7; k++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            expect_word(k, 32'(pat(k)), k + 1);
        end
        step(1'b0, 1'b1, 1'b1, 40);
        expect_word(7, 32'(pat(7)), 40);
        step(1'b0, 1'b1, 1'b0, 0);
        expect_word(40, 32'(pat(40)), 41);
        step(1'b0, 1'b1, 1'b1, 508);
        expect_word(41, 32'(pat(41)), 508);
        for (int k = 508; k < 512; k++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            expect_word(k, 32'(pat(k)), k + 1);
        end
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s4_valid", 32'(instr_valid), 0);
        chk("s4_done", 32'(done), 1);
        chk("s4_fault", 32'(fault), 1);
        chk("s4_pc_held", 32'(instr_pc), 511);
`ifdef FETCH_PERF_CNT_EN
        chk("s4_instr_count", 32'(instr_count), 14);
        chk("s4_stall_count", 32'(stall_count), 3);
`endif
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s4_sticky_done", 32'(done), 1);
        chk("s4_sticky_fault", 32'(fault), 1);
        chk("s4_sticky_valid", 32'(instr_valid), 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s4_restart_done", 32'(done), 0);
        chk("s4_restart_fault", 32'(fault), 0);
        chk("s4_restart_valid", 32'(instr_valid), 0);
        chk("s4_restart_addr", 32'(instr_addr), 0);

        // Asynchronous reset mid-run at instr_pc 20.
        for (int k = 0; k < 21; k++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            expect_word(k, 32'(pat(k)), k + 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("s5_async");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s5_idle_valid", 32'(instr_valid), 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("s5_lat_valid", 32'(instr_valid), 0);
        step(1'b0, 1'b1, 1'b0, 0);
        expect_word(0, 32'(pat(0)), 1);
        step(1'b0, 1'b1, 1'b0, 0);
        expect_word(1, 32'(pat(1)), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
